pattern_feeder: RTL and testbench

- Upstream stimulus stage for the sequence detector: converts a switch-loaded pattern plus a push-button "go" into a serial bit stream on b, one bit per step.
- Includes a 2-flop synchroniser and debouncer for go, a step prescaler, a shift register and a control FSM.
- b/b_stb feed the detector's b input; b_stb serves as the detector's clock enable when DIV>1.

---
 rtl/pattern_feeder_pkg.sv | 21 ++
 rtl/pattern_feeder_if.sv | 37 +++
 rtl/pattern_feeder_button_debounce.sv | 58 +++++
 rtl/pattern_feeder.sv | 134 +++++++++++++
 tb/tb_pattern_feeder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pattern_feeder_pkg                                              |
// | Purpose  : Shared types and helpers for the pattern feeder slice:          |
// |            control FSM state encoding and the bit-counter width function.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pattern_feeder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Width needed to count 0..width inclusive (len and bit_cnt).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pattern_feeder_if                                               |
// | Purpose  : Bundles the feeder's user-side inputs and detector-side outputs.|
// |   go       raw push-button level (to feeder)                               |
// |   pattern  bits to send, len number of bits (to feeder)                    |
// |   b/b_stb  serial bit and new-bit strobe (from feeder)                     |
// |   busy/done/bit_cnt  run status (from feeder)                              |
// |   master : feeder side, slave : stimulus/consumer side                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface pattern_feeder_if #(
  parameter int WIDTH = 16
);
  localparam int LW = pattern_feeder_pkg::cnt_width(WIDTH);

  logic             go;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic             b;
  logic             b_stb;
  logic             busy;
  logic             done;
  logic [LW-1:0]    bit_cnt;

  modport master (
    input  go, pattern, len,
    output b, b_stb, busy, done, bit_cnt
  );

  modport slave (
    output go, pattern, len,
    input  b, b_stb, busy, done, bit_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pattern_feeder_button_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : button_debounce                                                 |
// | Purpose  : Two-flop synchroniser, counter debouncer and rising-edge pulse  |
// |            for a bouncy asynchronous push-button.                          |
// |   clk   system clock          rst   asynchronous active-low reset          |
// |   raw   raw button input      level debounced level                        |
// |   rise  one-cycle pulse while level is newly high                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module button_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic raw,
  output logic      level,
  output logic      rise
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  // Combinational so the FSM sees start on the edge right after the level flips.
  assign rise  = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/pattern_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pattern_feeder                                                  |
// | Purpose  : Serialises a switch-loaded pattern onto b, one bit per DIV      |
// |            clocks, launched by a debounced push-button press.              |
// |   clk  system clock           rst  asynchronous active-low reset           |
// |   bus  pattern_feeder_if.master: go/pattern/len in,                        |
// |        b/b_stb/busy/done/bit_cnt out                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pattern_feeder
  import pattern_feeder_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV       = 1,
  parameter int DB_CYCLES = 4,
  parameter int MSB_FIRST = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pattern_feeder_if.master bus
);

  localparam int LW = cnt_width(WIDTH);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [LW-1:0] c_width_lw   = LW'(WIDTH);
  localparam logic [PW-1:0] c_presc_last = PW'(DIV - 1);
  localparam bit            c_msb_first  = (MSB_FIRST != 0);

  state_t           r_state;
  logic             r_b;
  logic             r_b_stb;
  logic             r_busy;
  logic             r_done;
  logic [LW-1:0]    r_bit_cnt;
  logic [LW-1:0]    r_len;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_shreg;

  logic             w_start;
  logic             w_unused_go_level;
  logic [LW-1:0]    w_eff_len;
  logic [WIDTH-1:0] w_aligned;
  logic             w_first;
  logic [WIDTH-1:0] w_aligned_adv;
  logic             w_head;
  logic [WIDTH-1:0] w_shreg_adv;

  button_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_go_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.go),
    .level (w_unused_go_level),
    .rise  (w_start)
  );

  assign w_eff_len = (bus.len > c_width_lw) ? c_width_lw : bus.len;

  // MSB-first runs left-justify the live bits so the outgoing bit is always
  // the register MSB; LSB-first runs shift out of bit 0 unchanged.
  assign w_aligned     = c_msb_first ? (bus.pattern << (c_width_lw - w_eff_len)) : bus.pattern;
  assign w_first       = c_msb_first ? w_aligned[WIDTH-1] : w_aligned[0];
  assign w_aligned_adv = c_msb_first ? (w_aligned << 1) : (w_aligned >> 1);
  assign w_head        = c_msb_first ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shreg_adv   = c_msb_first ? (r_shreg << 1) : (r_shreg >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_b       <= 1'b0;
      r_b_stb   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_cnt <= '0;
      r_len     <= '0;
      r_presc   <= '0;
      r_shreg   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_b_stb <= 1'b0;
          if (w_start) begin
            if (w_eff_len == '0) begin
              // Zero-length run: acknowledge the press without shifting.
              r_done    <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_state   <= ST_SHIFT;
              r_len     <= w_eff_len;
              r_b       <= w_first;
              r_shreg   <= w_aligned_adv;
              r_b_stb   <= 1'b1;
              r_busy    <= 1'b1;
              r_bit_cnt <= LW'(1);
              r_presc   <= '0;
            end
          end
        end
        ST_SHIFT: begin
          if (r_presc == c_presc_last) begin
            if (r_bit_cnt < r_len) begin
              r_b       <= w_head;
              r_shreg   <= w_shreg_adv;
              r_b_stb   <= 1'b1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_presc   <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_b     <= 1'b0;
              r_b_stb <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
            r_b_stb <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.b       = r_b;
  assign bus.b_stb   = r_b_stb;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pattern_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pattern_feeder                                               |
// | Purpose  : Self-checking bench for pattern_feeder. Two instances share the |
// |            stimulus: dut_a (DIV=1, MSB first) and dut_b (DIV=3, LSB first).|
// |            Each run's per-cycle b/b_stb waveform is compared against a     |
// |            model built from the bit-order and hold-time rules.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pattern_feeder;

  localparam int WIDTH = 16;
  localparam int LW    = pattern_feeder_pkg::cnt_width(WIDTH);
  localparam int DB    = 4;

  logic             clk_tb = 1'b0;
  logic             rst    = 1'b0;
  logic             go     = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LW-1:0]    len     = '0;

  int checks   = 0;
  int failures = 0;

  pattern_feeder_if #(.WIDTH(WIDTH)) if_a ();
  pattern_feeder_if #(.WIDTH(WIDTH)) if_b ();

  assign if_a.go = go;  assign if_a.pattern = pattern;  assign if_a.len = len;
  assign if_b.go = go;  assign if_b.pattern = pattern;  assign if_b.len = len;

  pattern_feeder #(.WIDTH(WIDTH), .DIV(1), .DB_CYCLES(DB), .MSB_FIRST(1)) dut_a (
    .clk (clk_tb), .rst (rst), .bus (if_a.master)
  );

  pattern_feeder #(.WIDTH(WIDTH), .DIV(3), .DB_CYCLES(DB), .MSB_FIRST(0)) dut_b (
    .clk (clk_tb), .rst (rst), .bus (if_b.master)
  );

  always #5 clk_tb = ~clk_tb;

  // Observation: per-cycle b and b_stb while busy, bit i = i-th busy cycle.
  logic [63:0] obs_w [2];
  logic [63:0] obs_s [2];
  int          obs_n [2];
  int          done_n[2];
  int          stray [2];

  task automatic sample(input int k, input logic busy_v, input logic b_v,
                        input logic stb_v, input logic done_v);
    if (busy_v) begin
      if (obs_n[k] < 64) begin
        obs_w[k][obs_n[k]] = b_v;
        obs_s[k][obs_n[k]] = stb_v;
      end
      obs_n[k]++;
    end else if (b_v || stb_v) begin
      stray[k]++;
    end
    if (done_v) done_n[k]++;
  endtask

  always @(negedge clk_tb) sample(0, if_a.busy, if_a.b, if_a.b_stb, if_a.done);
  always @(negedge clk_tb) sample(1, if_b.busy, if_b.b, if_b.b_stb, if_b.done);

  task automatic clear_obs();
    for (int k = 0; k < 2; k++) begin
      obs_w[k] = '0; obs_s[k] = '0; obs_n[k] = 0; done_n[k] = 0; stray[k] = 0;
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: each of the n bits, in send order, repeated div cycles.
  function automatic logic [63:0] exp_wave(input logic [15:0] pat, input int n,
                                           input int div, input bit msb);
    logic [63:0] w = '0;
    int          p = 0;
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < div; d++) begin
        w[p] = msb ? pat[n-1-i] : pat[i];
        p++;
      end
    end
    return w;
  endfunction

  function automatic logic [63:0] exp_stb(input int n, input int div);
    logic [63:0] s = '0;
    for (int i = 0; i < n * div; i++) s[i] = ((i % div) == 0);
    return s;
  endfunction

  task automatic check_dut(input string tag, input int k, input int div, input bit msb,
                           input logic [15:0] pat, input int n, input logic [LW-1:0] bc);
    check({tag, "/busy_cycles"}, 64'(obs_n[k]), 64'(n * div));
    check({tag, "/b_wave"},      obs_w[k], exp_wave(pat, n, div, msb));
    check({tag, "/stb_wave"},    obs_s[k], exp_stb(n, div));
    check({tag, "/done_pulses"}, 64'(done_n[k]), 64'd1);
    check({tag, "/idle_quiet"},  64'(stray[k]), 64'd0);
    if (n > 0) check({tag, "/bit_cnt"}, 64'(bc), 64'(n));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_tb);
  endtask

  // mode 0: clean press; 1: bouncy press; 2: re-press and input change while busy.
  task automatic do_run(input string tag, input logic [15:0] pat, input int ln,
                        input int mode, input int n);
    pattern = pat;
    len     = LW'(ln);
    clear_obs();
    case (mode)
      1: begin
        go = 1'b1; wait_cyc(2); go = 1'b0; wait_cyc(2); go = 1'b1;
      end
      2: begin
        go = 1'b1; wait_cyc(9);
        go = 1'b0; pattern = ~pat; len = LW'(3); wait_cyc(6);
        go = 1'b1;
      end
      default: go = 1'b1;
    endcase
    wait_cyc(70);
    go = 1'b0;
    wait_cyc(12);
    check_dut({tag, "/a"}, 0, 1, 1'b1, pat, n, if_a.bit_cnt);
    check_dut({tag, "/b"}, 1, 3, 1'b0, pat, n, if_b.bit_cnt);
  endtask

  typedef struct {
    logic [15:0] pat;
    int          len;
    int          mode;
    int          exp_n;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] seq_a;
    logic [11:0] wave_b, stb_b;
    int          lat;
    bit          hit;

    tbl[0] = '{16'h5637, 15, 1, 15};
    tbl[1] = '{16'h0005,  4, 0,  4};
    tbl[2] = '{16'hBEEF, 20, 0, 16};
    tbl[3] = '{16'h1234,  0, 0,  0};
    tbl[4] = '{16'h8001,  1, 0,  1};
    tbl[5] = '{16'hC3A5, 15, 2, 15};

    // Reset held with go high: everything quiet.
    clear_obs();
    rst = 1'b0; go = 1'b1; pattern = 16'h5637; len = LW'(15);
    wait_cyc(4);
    check("reset/a_outputs", 64'({if_a.b, if_a.b_stb, if_a.busy, if_a.done, if_a.bit_cnt}), 64'd0);
    check("reset/b_outputs", 64'({if_b.b, if_b.b_stb, if_b.busy, if_b.done, if_b.bit_cnt}), 64'd0);

    // Release with go still high: first strobe DB+3 edges later.
    clear_obs();
    rst = 1'b1;
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk_tb);
      if (if_a.b_stb) begin lat = e; break; end
    end
    check("latency/a", 64'(lat), 64'(DB + 3));
    check("latency/b_stb", 64'(if_b.b_stb), 64'd1);
    wait_cyc(60);
    go = 1'b0;
    wait_cyc(12);
    check_dut("detect/a", 0, 1, 1'b1, 16'h5637, 15, if_a.bit_cnt);
    check_dut("detect/b", 1, 3, 1'b0, 16'h5637, 15, if_b.bit_cnt);
    seq_a = 15'b111011000110101;
    check("detect/a_seq", 64'(obs_w[0][14:0]), 64'(seq_a));

    for (int i = 0; i < 6; i++) begin
      do_run($sformatf("tbl%0d", i), tbl[i].pat, tbl[i].len, tbl[i].mode, tbl[i].exp_n);
      if (i == 1) begin
        wave_b = 12'b000111000111;
        stb_b  = 12'b001001001001;
        check("div3/b_wave", 64'(obs_w[1][11:0]), 64'(wave_b));
        check("div3/b_stb",  64'(obs_s[1][11:0]), 64'(stb_b));
      end
    end

    // Abort at bit 5: immediate zeroing, no done.
    pattern = 16'h5637; len = LW'(15);
    clear_obs();
    go = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_tb);
      if (if_a.bit_cnt == LW'(5)) begin hit = 1'b1; break; end
    end
    check("abort/reach_bit5", 64'(hit), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("abort/a_outputs", 64'({if_a.b, if_a.b_stb, if_a.busy, if_a.done, if_a.bit_cnt}), 64'd0);
    check("abort/b_outputs", 64'({if_b.b, if_b.b_stb, if_b.busy, if_b.done, if_b.bit_cnt}), 64'd0);
    wait_cyc(3);
    go = 1'b0;
    wait_cyc(2);
    check("abort/no_done", 64'(done_n[0] + done_n[1]), 64'd0);
    rst = 1'b1;
    wait_cyc(12);
    do_run("after_abort", 16'h5637, 15, 0, 15);

    // Randomised runs, including len beyond WIDTH and zero.
    for (int r = 0; r < 6; r++) begin
      logic [15:0] rp;
      int          rl;
      rp = 16'($urandom);
      rl = int'($urandom_range(0, 20));
      do_run($sformatf("rand%0d", r), rp, rl, 0, (rl > WIDTH) ? WIDTH : rl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
